// File: rtl/priority_bitmap_decoder.sv
// Priority bitmap decoder: rebuilds a 16-bit bitmap from a stream of descending
// bit-index codes terminated by 0xF0, then holds the frame until it is consumed.
module priority_bitmap_decoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_code,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_a,
    output logic [7:0] out_b,
    output logic [4:0] out_count,
    output logic       out_err
);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_t;

    localparam logic [7:0] EOF_CODE  = 8'hF0;
    localparam logic [4:0] COUNT_MAX = 5'd31;

    state_t      state_r;
    logic [15:0] acc_r;
    logic [4:0]  count_r;
    logic        err_r;
    logic        prev_vld_r;
    logic [3:0]  prev_idx_r;

    logic        accept_s;
    logic        is_index_s;
    logic        is_eof_s;
    logic        order_bad_s;
    logic [15:0] onehot_s;

    // Classify the incoming code and check it against the previous index of the frame.
    always_comb begin
        accept_s    = 1'b0;
        is_index_s  = 1'b0;
        is_eof_s    = 1'b0;
        order_bad_s = 1'b0;
        onehot_s    = 16'h0000;
        if (in_valid && (state_r == ST_COLLECT)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        if (in_code[7:4] == 4'h0) begin
            is_index_s = 1'b1;
        end else begin
            is_index_s = 1'b0;
        end
        if (in_code == EOF_CODE) begin
            is_eof_s = 1'b1;
        end else begin
            is_eof_s = 1'b0;
        end
        // Indices must strictly descend; the first index of a frame is unconstrained.
        if (prev_vld_r && (in_code[3:0] >= prev_idx_r)) begin
            order_bad_s = 1'b1;
        end else begin
            order_bad_s = 1'b0;
        end
        onehot_s = 16'h0001 << in_code[3:0];
    end

    // Frame FSM with accumulator, saturating count, error flag and previous-index record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_COLLECT;
            acc_r      <= 16'h0000;
            count_r    <= 5'd0;
            err_r      <= 1'b0;
            prev_vld_r <= 1'b0;
            prev_idx_r <= 4'h0;
        end else begin
            case (state_r)
                ST_COLLECT: begin
                    if (accept_s) begin
                        if (is_index_s) begin
                            acc_r      <= acc_r | onehot_s;
                            prev_idx_r <= in_code[3:0];
                            prev_vld_r <= 1'b1;
                            if (count_r != COUNT_MAX) begin
                                count_r <= count_r + 5'd1;
                            end
                            if (order_bad_s) begin
                                err_r <= 1'b1;
                            end
                        end else if (is_eof_s) begin
                            state_r <= ST_HOLD;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_r    <= ST_COLLECT;
                        acc_r      <= 16'h0000;
                        count_r    <= 5'd0;
                        err_r      <= 1'b0;
                        prev_vld_r <= 1'b0;
                        prev_idx_r <= 4'h0;
                    end
                end
                default: begin
                    state_r <= ST_COLLECT;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == ST_COLLECT);
    assign out_valid = (state_r == ST_HOLD);
    assign out_a     = acc_r[15:8];
    assign out_b     = acc_r[7:0];
    assign out_count = count_r;
    assign out_err   = err_r;

endmodule

// File: tb/tb_priority_bitmap_decoder.sv
// Self-checking bench: frame-level reference model compared every cycle, plus
// hand-computed expectations for the documented scenarios and saturation.
module tb_priority_bitmap_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_code = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_a;
    logic [7:0] out_b;
    logic [4:0] out_count;
    logic       out_err;

    int errors = 0;
    int checks = 0;

    // Reference model: the indices accepted in the current frame, an illegal flag, hold flag
    int q[$];
    bit m_ill  = 1'b0;
    bit m_hold = 1'b0;

    priority_bitmap_decoder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_count(out_count), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_bits();
        logic [15:0] b = 16'h0000;
        foreach (q[i]) b[q[i]] = 1'b1;
        return b;
    endfunction

    function automatic int m_count();
        return (q.size() > 31) ? 31 : q.size();
    endfunction

    function automatic bit m_err();
        bit e = m_ill;
        for (int i = 1; i < q.size(); i++) if (q[i] >= q[i-1]) e = 1'b1;
        return e;
    endfunction

    // Model update on each clock edge and on asynchronous reset
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete(); m_ill = 1'b0; m_hold = 1'b0;
            end else if (m_hold) begin
                if (out_ready) begin
                    q.delete(); m_ill = 1'b0; m_hold = 1'b0;
                end
            end else if (in_valid) begin
                if (in_code < 8'h10) q.push_back(int'(in_code));
                else if (in_code == 8'hF0) m_hold = 1'b1;
                else m_ill = 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    initial begin
        logic [15:0] b;
        forever begin
            @(negedge clk);
            b = m_bits();
            chk("cyc_in_ready",  32'(in_ready),  32'(!m_hold));
            chk("cyc_out_valid", 32'(out_valid), 32'(m_hold));
            chk("cyc_out_a",     32'(out_a),     32'(b[15:8]));
            chk("cyc_out_b",     32'(out_b),     32'(b[7:0]));
            chk("cyc_out_count", 32'(out_count), 32'(m_count()));
            chk("cyc_out_err",   32'(out_err),   32'(m_err()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c);
        in_valid = 1'b1;
        in_code  = c;
        step();
        in_valid = 1'b0;
    endtask

    task automatic release_frame();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [7:0] a,
                              input logic [7:0] b, input logic [4:0] c, input logic e);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_a"},     32'(out_a),     32'(a));
        chk({tag, "_b"},     32'(out_b),     32'(b));
        chk({tag, "_count"}, 32'(out_count), 32'(c));
        chk({tag, "_err"},   32'(out_err),   32'(e));
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        expect_out("rst", 1'b0, 8'h00, 8'h00, 5'd0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        int r;
        repeat (2) step();
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        expect_out("reset", 1'b0, 8'h00, 8'h00, 5'd0, 1'b0);
        #2 rst_n = 1'b1;
        step();

        // Normal frame, accepted on the first edge after reset release
        send(8'h0F); send(8'h03); send(8'hF0);
        expect_out("normal", 1'b1, 8'h80, 8'h08, 5'd2, 1'b0);

        // Backpressure: input offered while holding must be ignored
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_code = 8'h01; out_ready = 1'b0;
            step();
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            expect_out("bp", 1'b1, 8'h80, 8'h08, 5'd2, 1'b0);
        end
        in_valid = 1'b0;
        release_frame();
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        expect_out("rel", 1'b0, 8'h00, 8'h00, 5'd0, 1'b0);
        send(8'h01); send(8'hF0);
        expect_out("after_bp", 1'b1, 8'h00, 8'h02, 5'd1, 1'b0);
        release_frame();

        send(8'hF0);
        expect_out("empty", 1'b1, 8'h00, 8'h00, 5'd0, 1'b0);
        release_frame();

        send(8'h02); send(8'h05); send(8'hF0);
        expect_out("order", 1'b1, 8'h00, 8'h24, 5'd2, 1'b1);
        release_frame();

        send(8'h20); send(8'hF0);
        expect_out("illegal", 1'b1, 8'h00, 8'h00, 5'd0, 1'b1);
        release_frame();

        // Reset mid-frame discards the partial frame
        send(8'h0A);
        expect_out("partial", 1'b0, 8'h04, 8'h00, 5'd1, 1'b0);
        pulse_reset();
        send(8'hF0);
        expect_out("post_rst", 1'b1, 8'h00, 8'h00, 5'd0, 1'b0);
        release_frame();

        // Count saturates at 31; wrap from 0 back to 15 is an ordering error
        for (int i = 0; i < 35; i++) send(8'(15 - (i % 16)));
        send(8'hF0);
        expect_out("sat", 1'b1, 8'hFF, 8'hFF, 5'd31, 1'b1);
        release_frame();

        // Duplicate index is an ordering error but still counts
        send(8'h07); send(8'h07); send(8'hF0);
        expect_out("dup", 1'b1, 8'h00, 8'h80, 5'd2, 1'b1);
        release_frame();

        // Randomized traffic checked by the every-cycle model compare
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            r         = $urandom_range(0, 19);
            if (r < 14)      in_code = 8'($urandom_range(0, 15));
            else if (r < 17) in_code = 8'hF0;
            else if (r < 18) in_code = 8'($urandom_range(16, 239));
            else             in_code = 8'($urandom_range(241, 255));
            out_ready = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset();
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/priority_bitmap_decoder.md
PRIORITY_BITMAP_DECODER -- requirements
Module: priority_bitmap_decoder

Interface
REQ-001 The block SHALL have these ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_code is valid this cycle.
- in_ready  output  1  block accepts in_code this cycle.
- in_code  input  8  encoded symbol:
  - 0x00-0x0F: bit index.
  - 0xF0: end-of-frame ("no bit set").
  - any other value: illegal.
- out_valid  output  1  reconstructed frame available.
- out_ready  input  1  consumer takes the frame this cycle.
- out_a  output  8  reconstructed bits 15:8.
- out_b  output  8  reconstructed bits 7:0.
- out_count  output  5  number of index codes accepted in the frame.
- out_err  output  1  frame contained an ordering violation or an illegal code.

REQ-002 The block SHALL have no parameters; all widths are fixed as listed.

Function
REQ-003 The block SHALL be a two-state FSM: COLLECT and HOLD.

REQ-004 in_ready SHALL be 1 in COLLECT and 0 in HOLD; out_valid SHALL be 0 in COLLECT and 1 in HOLD. Both SHALL be decoded from state only.

REQ-005 Accept event: in_valid=1 and in_ready=1 at a rising edge.

REQ-006 An accepted index code k (in_code[7:4]==0) SHALL:
- set bit k of a 16-bit accumulator (bit k is already set: no change);
- increment out_count, saturating at 31.

REQ-007 An index code SHALL be strictly less than the previous accepted index code of the same frame. Otherwise (including a duplicate index) err SHALL be set, and REQ-006 still applies.

REQ-008 The first index code of a frame SHALL have no ordering constraint.

REQ-009 An accepted illegal code SHALL set err and SHALL NOT change the accumulator or out_count.

REQ-010 An accepted 0xF0 SHALL move the FSM to HOLD. out_valid SHALL be high in the cycle after the accept edge (1-cycle latency).

REQ-011 In HOLD, the outputs SHALL be:
- out_a = accumulator[15:8];
- out_b = accumulator[7:0];
- out_count and out_err per REQ-006 to REQ-009.
All four SHALL stay constant until out_ready=1.

REQ-012 In HOLD, out_ready=1 at a rising edge SHALL:
- clear the accumulator, out_count, err and the previous-index record;
- return the FSM to COLLECT, with in_ready=1 in the next cycle.

REQ-013 in_code SHALL be ignored whenever in_ready=0, including when in_valid=1.

REQ-014 A frame consisting only of 0xF0 SHALL produce out_a=0x00, out_b=0x00, out_count=0, out_err=0.

REQ-015 In COLLECT, out_a, out_b, out_count and out_err SHALL reflect the running accumulator and flags.

REQ-016 in_valid=0 in COLLECT SHALL hold all state; there is no timeout.

Reset
REQ-017 rst_n=0 SHALL immediately force:
- FSM to COLLECT;
- accumulator, out_count, err and previous-index record to zero;
- out_valid=0, in_ready=1.

REQ-018 Reset asserted in the middle of a frame SHALL discard that frame completely; no partial output SHALL appear.

REQ-019 The block SHALL accept input on the first rising edge after rst_n deasserts.

Verification
REQ-020 Normal frame: codes 0x0F, 0x03, 0xF0 -> one cycle later out_valid=1, out_a=0x80, out_b=0x08, out_count=2, out_err=0.

REQ-021 Empty frame: code 0xF0 alone -> out_valid=1, out_a=0x00, out_b=0x00, out_count=0, out_err=0.

REQ-022 Order violation: codes 0x02, 0x05, 0xF0 -> out_a=0x00, out_b=0x24, out_count=2, out_err=1.

REQ-023 Illegal code: codes 0x20, 0xF0 -> out_a=0x00, out_b=0x00, out_count=0, out_err=1.

REQ-024 Backpressure:
- Stimulus: after the REQ-020 frame, hold out_ready=0 for 5 cycles while in_valid=1 with in_code=0x01.
- Required: in_ready=0 and outputs constant throughout.
- Then: out_ready=1 for 1 cycle, followed by codes 0x01, 0xF0 -> out_b=0x02, out_a=0x00, out_count=1, out_err=0.

REQ-025 Reset mid-frame:
- Stimulus: code 0x0A accepted, then rst_n pulsed low, then code 0xF0.
- Required: out_a=0x00, out_b=0x00, out_count=0, out_err=0.
